tristate_bus_arbiter: RTL

// Upstream control stage for the two-source tristate mux. Arbitrates source A and

---
 rtl/tristate_bus_arbiter_pkg.sv | 36 +++
 rtl/tristate_bus_arbiter_if.sv | 22 ++
 rtl/tristate_bus_arbiter_hold_counter.sv | 29 ++
 rtl/tristate_bus_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types for the two-source tristate bus arbiter: FSM state encoding,
// owner identity, mux select values and the round-robin arbitration helper.
package tristate_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        TURN    = 2'd3
    } arbState_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Round-robin pick: a lone requester wins outright, a tie goes to whoever
    // did not own the bus last.
    function automatic arbState_t arbitrate(input logic reqA, input logic reqB,
                                            input owner_t lastOwner);
        arbState_t result;
        result = IDLE;
        if (reqA && reqB) begin
            result = (lastOwner == OWNER_A) ? GRANT_B : GRANT_A;
        end else if (reqA) begin
            result = GRANT_A;
        end else if (reqB) begin
            result = GRANT_B;
        end
        return result;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant bundle between the arbiter and the two bus sources.
// The arbiter side is the master; the sources (or a bench) use the slave view.
interface tristate_bus_arbiter_if;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic oe_a;
    logic oe_b;
    logic sel;
    logic busy;

    modport master (
        input  req_a, req_b,
        output gnt_a, gnt_b, oe_a, oe_b, sel, busy
    );

    modport slave (
        output req_a, req_b,
        input  gnt_a, gnt_b, oe_a, oe_b, sel, busy
    );
endinterface

// File: rtl/tristate_bus_arbiter_hold_counter.sv
// Saturating up-counter with synchronous clear and count enable. The terminal
// flag is high while the count sits at LAST; the counter then stops there.
module arb_hold_counter #(
    parameter int                WIDTH = 4,
    parameter logic [WIDTH-1:0]  LAST  = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    logic [WIDTH-1:0] count_q;

    // Clear wins over enable; counting stops once the terminal value is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc_o = (count_q == LAST);

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Two-source tristate bus arbiter: round-robin on ties, bounded hold while the
// other source waits, and an optional all-off turnaround gap between owners.
// Every output comes straight from a flop so the enables never glitch.
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD    = 4,
    parameter int TURN_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    tristate_bus_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);

    arbState_t state_q;
    arbState_t state_d;
    owner_t    lastOwner_q;
    logic      gntA_q;
    logic      gntB_q;
    logic      sel_q;
    logic      busy_q;

    logic      releaseNow;
    logic      holdTc;
    logic      holdEnable;
    logic      holdClear;
    logic      turnTc;
    logic      turnEnable;
    logic      turnClear;

    // The hold counter runs only while a grant is held and restarts at every release.
    assign holdEnable = (state_q == GRANT_A) || (state_q == GRANT_B);
    assign holdClear  = !holdEnable || releaseNow;
    assign turnEnable = (state_q == TURN);
    assign turnClear  = !turnEnable;

    arb_hold_counter #(.WIDTH(CNT_W), .LAST(HOLD_LAST)) holdCounter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (holdClear),
        .enable_i (holdEnable),
        .tc_o     (holdTc)
    );

    arb_hold_counter #(.WIDTH(CNT_W), .LAST(TURN_LAST)) turnCounter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (turnClear),
        .enable_i (turnEnable),
        .tc_o     (turnTc)
    );

    // Next-state decision; a release goes either to the gap or straight to re-arbitration.
    always_comb begin
        state_d    = state_q;
        releaseNow = 1'b0;
        case (state_q)
            IDLE:    state_d = arbitrate(bus.req_a, bus.req_b, lastOwner_q);
            GRANT_A: releaseNow = !bus.req_a || (bus.req_b && holdTc);
            GRANT_B: releaseNow = !bus.req_b || (bus.req_a && holdTc);
            TURN:    if (turnTc) state_d = arbitrate(bus.req_a, bus.req_b, lastOwner_q);
            default: state_d = IDLE;
        endcase
        if (releaseNow) begin
            state_d = (TURN_CYCLES > 0) ? TURN : arbitrate(bus.req_a, bus.req_b, lastOwner_q);
        end
    end

    // State plus registered outputs; sel and owner only move on the edge a new grant starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lastOwner_q <= OWNER_B;
            gntA_q      <= 1'b0;
            gntB_q      <= 1'b0;
            sel_q       <= SEL_A;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            gntA_q  <= (state_d == GRANT_A);
            gntB_q  <= (state_d == GRANT_B);
            busy_q  <= (state_d != IDLE);
            if ((state_d == GRANT_A) && (state_q != GRANT_A)) begin
                sel_q       <= SEL_A;
                lastOwner_q <= OWNER_A;
            end else if ((state_d == GRANT_B) && (state_q != GRANT_B)) begin
                sel_q       <= SEL_B;
                lastOwner_q <= OWNER_B;
            end
        end
    end

    assign bus.gnt_a = gntA_q;
    assign bus.gnt_b = gntB_q;
    assign bus.oe_a  = gntA_q;
    assign bus.oe_b  = gntB_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;

endmodule
